// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

  typedef logic [6:0] seg7_t;

  // Cathode pattern with every segment off (active-low).
  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F, index = nibble value.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational nibble to active-low seven-segment pattern.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg7_t      seg_c
);

  assign seg_c = HEX_SEG[nib_i];

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed N-digit common-anode scanner with leading-zero suppression,
// PWM dimming and frame-synchronous (tear-free) data update.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIM_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     blank,
  input  logic                    lz_en,
  input  logic [DIM_BITS-1:0]     brightness,
  input  logic                    load,
  output logic [N_DIGITS-1:0]     sseg_an,
  output logic [6:0]              sseg_ca,
  output logic                    sseg_dp,
  output logic                    frame
);

  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned LIM_W   = $clog2(REFRESH_DIV + 1);
  localparam int unsigned SLOT_W  = $clog2(N_DIGITS);
  localparam int unsigned STEP    = REFRESH_DIV >> DIM_BITS;

  logic [PRESC_W-1:0]          presc_q, presc_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [N_DIGITS-1:0][3:0]    stg_dig_q, act_dig_q;
  logic [N_DIGITS-1:0]         stg_dp_q, act_dp_q;
  logic [N_DIGITS-1:0]         stg_blank_q, act_blank_q;
  logic                        stg_lz_q, act_lz_q;
  logic                        wrap_q, frame_q;
  logic [N_DIGITS-1:0]         an_q, an_d;
  seg7_t                       ca_q, ca_d;
  logic                        dp_q, dp_d;

  logic                        tc_c, wrap_c;
  logic [N_DIGITS-1:0]         sup_c;
  logic                        zrun_c;
  logic [3:0]                  cur_dig_c;
  seg7_t                       seg_c;
  logic [LIM_W-1:0]            lim_c;
  logic                        on_time_c, seg_on_c, dp_on_c;

  // Prescaler and slot counter
  always_comb begin
    tc_c    = (presc_q == PRESC_W'(REFRESH_DIV - 1));
    wrap_c  = tc_c && (slot_q == SLOT_W'(N_DIGITS - 1));
    presc_d = tc_c ? '0 : presc_q + PRESC_W'(1);
    slot_d  = slot_q;
    if (tc_c) slot_d = (slot_q == SLOT_W'(N_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
  end

  // Zero run from the top digit down; digit 0 always stays visible.
  always_comb begin
    sup_c  = '0;
    zrun_c = act_lz_q;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zrun_c   = zrun_c && (act_dig_q[k] == 4'h0);
      sup_c[k] = zrun_c;
    end
  end

  assign cur_dig_c = act_dig_q[slot_q];

  sseg_hex_decoder u_dec (
    .nib_i (cur_dig_c),
    .seg_c (seg_c)
  );

  // Pin values for the current slot; a suppressed digit may still light its dp.
  always_comb begin
    an_d      = '1;
    ca_d      = SEG_BLANK;
    dp_d      = 1'b1;
    lim_c     = (LIM_W'(brightness) + LIM_W'(1)) * LIM_W'(STEP);
    on_time_c = LIM_W'(presc_q) < lim_c;
    seg_on_c  = !act_blank_q[slot_q] && !sup_c[slot_q];
    dp_on_c   = !act_blank_q[slot_q] && act_dp_q[slot_q];
    if (on_time_c && (seg_on_c || dp_on_c)) begin
      an_d = ~(N_DIGITS'(1) << slot_q);
      if (seg_on_c) ca_d = seg_c;
      if (dp_on_c)  dp_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      slot_q      <= '0;
      stg_dig_q   <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '0;
      stg_lz_q    <= 1'b0;
      act_dig_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      act_lz_q    <= 1'b0;
      wrap_q      <= 1'b0;
      frame_q     <= 1'b0;
      an_q        <= '1;
      ca_q        <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      if (load) begin
        stg_dig_q   <= digits;
        stg_dp_q    <= dp;
        stg_blank_q <= blank;
        stg_lz_q    <= lz_en;
      end
      // Active copy happens only at the frame boundary and sees the pre-load staging.
      if (wrap_c) begin
        act_dig_q   <= stg_dig_q;
        act_dp_q    <= stg_dp_q;
        act_blank_q <= stg_blank_q;
        act_lz_q    <= stg_lz_q;
      end
      // Two stages so the pulse lines up with slot 0 appearing on the pins.
      wrap_q  <= wrap_c;
      frame_q <= wrap_q;
      an_q    <= an_d;
      ca_q    <= ca_d;
      dp_q    <= dp_d;
    end
  end

  assign sseg_an = an_q;
  assign sseg_ca = ca_q;
  assign sseg_dp = dp_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed, table-driven bench for sseg_scan_ctrl (4 digits, 8-cycle slots, 2-bit dimming).
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [1:0]  brightness;
  logic        load;
  logic [3:0]  sseg_an;
  logic [6:0]  sseg_ca;
  logic        sseg_dp;
  logic        frame;

  int checks;
  int failures;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [1:0]      br;
    logic [3:0][3:0] an;   // expected anodes per slot while in on-time
    logic [3:0][6:0] ca;   // expected cathodes per slot while in on-time
    logic [3:0]      dpo;  // expected dp pin per slot while in on-time
    int              lit;  // on-time cycles per 8-cycle slot
  } vec_t;

  vec_t vecs[8];

  sseg_scan_ctrl #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .DIM_BITS    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dp         (dp),
    .blank      (blank),
    .lz_en      (lz_en),
    .brightness (brightness),
    .load       (load),
    .sseg_an    (sseg_an),
    .sseg_ca    (sseg_ca),
    .sseg_dp    (sseg_dp),
    .frame      (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", 32'(frame), 32'd1);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    digits     = v.digits;
    dp         = v.dp;
    blank      = v.blank;
    lz_en      = v.lz;
    brightness = v.br;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    @(negedge clk);
    wait_frame();
  endtask

  // Starting on a frame-pulse cycle, check all 32 pin cycles of one scan.
  task automatic check_frame(input vec_t v, input int idx);
    logic [3:0] ea;
    logic [6:0] ec;
    logic       ed;
    for (int i = 0; i < 32; i++) begin
      int s, p;
      s = i / 8;
      p = i % 8;
      if (p < v.lit) begin
        ea = v.an[s];
        ec = v.ca[s];
        ed = v.dpo[s];
      end else begin
        ea = 4'hF;
        ec = 7'h7F;
        ed = 1'b1;
      end
      chk($sformatf("v%0d_an_i%0d", idx, i), 32'(sseg_an), 32'(ea));
      chk($sformatf("v%0d_ca_i%0d", idx, i), 32'(sseg_ca), 32'(ec));
      chk($sformatf("v%0d_dp_i%0d", idx, i), 32'(sseg_dp), 32'(ed));
      chk($sformatf("v%0d_frame_i%0d", idx, i), 32'(frame), (i == 0) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    digits     = '0;
    dp         = '0;
    blank      = '0;
    lz_en      = 1'b0;
    brightness = 2'd0;
    load       = 1'b0;

    vecs[0] = '{16'h3210, 4'b0000, 4'b0000, 1'b0, 2'd3,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111, 8};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 2'd3,
                {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111, 8};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 2'd3,
                {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 8};
    vecs[3] = '{16'h3210, 4'b0000, 4'b0000, 1'b0, 2'd0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111, 2};
    vecs[4] = '{16'h3210, 4'b0000, 4'b0000, 1'b0, 2'd2,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111, 6};
    vecs[5] = '{16'h3210, 4'b0100, 4'b0001, 1'b0, 2'd3,
                {4'b0111, 4'b1011, 4'b1101, 4'b1111}, {7'h30, 7'h24, 7'h79, 7'h7F}, 4'b1011, 8};
    vecs[6] = '{16'h0000, 4'b1000, 4'b0000, 1'b1, 2'd3,
                {4'b0111, 4'b1111, 4'b1111, 4'b1110}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111, 8};
    vecs[7] = '{16'h8FA1, 4'b0000, 4'b0000, 1'b0, 2'd1,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {7'h00, 7'h0E, 7'h08, 7'h79}, 4'b1111, 4};

    // Reset values, then first lit cycle right after release.
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(sseg_an), 32'hF);
    chk("rst_ca", 32'(sseg_ca), 32'h7F);
    chk("rst_dp", 32'(sseg_dp), 32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an", 32'(sseg_an), 32'hE);
    chk("first_ca", 32'(sseg_ca), 32'h40);

    for (int v = 0; v < 8; v++) begin
      apply(vecs[v]);
      check_frame(vecs[v], v);
    end

    // Mid-frame load stays hidden until the next frame boundary.
    apply(vecs[0]);
    repeat (10) @(negedge clk);
    digits = 16'h8FA1;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (13) @(negedge clk);
    chk("midload_old_an", 32'(sseg_an), 32'h7);
    chk("midload_old_ca", 32'(sseg_ca), 32'h30);
    wait_frame();
    chk("midload_new_an", 32'(sseg_an), 32'hE);
    chk("midload_new_ca", 32'(sseg_ca), 32'h79);

    // Load on the wrap cycle lands one frame later.
    repeat (30) @(negedge clk);
    digits = 16'h3210;
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("wrapload_f1_frame", 32'(frame), 32'd1);
    chk("wrapload_f1_ca", 32'(sseg_ca), 32'h79);
    repeat (32) @(negedge clk);
    chk("wrapload_f2_frame", 32'(frame), 32'd1);
    chk("wrapload_f2_ca", 32'(sseg_ca), 32'h40);

    // Asynchronous reset in the middle of slot 2.
    repeat (20) @(negedge clk);
    chk("prerst_an", 32'(sseg_an), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("midrst_an", 32'(sseg_an), 32'hF);
    chk("midrst_ca", 32'(sseg_ca), 32'h7F);
    chk("midrst_dp", 32'(sseg_dp), 32'd1);
    chk("midrst_frame", 32'(frame), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_an", 32'(sseg_an), 32'hE);
    chk("postrst_ca", 32'(sseg_ca), 32'h40);
    repeat (8) @(negedge clk);
    chk("postrst_s1_an", 32'(sseg_an), 32'hD);
    chk("postrst_s1_ca", 32'(sseg_ca), 32'h40);
    chk("postrst_s1_frame", 32'(frame), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
